// File: rtl/pc_unit.sv
// Fetch program counter: sequential advance, redirects, trap entry/return and halt,
// with saved exception PC and a registered misaligned-target pulse.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     INC          = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_req,
    input  logic            mret,
    input  logic            halt_req,
    output logic [XLEN-1:0] PC,
    output logic            pc_valid,
    output logic [XLEN-1:0] PC_plus_inc,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] IncVal    = XLEN'(INC);
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (mret) begin
                    pc_d = epc_q;
                end else if (jump) begin
                    // Misaligned redirect targets divert to the trap vector
                    if ((jump_target & AlignMask) != '0) begin
                        mis_d = 1'b1;
                        epc_d = pc_q;
                        pc_d  = TRAP_VECTOR;
                    end else begin
                        pc_d = jump_target;
                    end
                end else if (branch_taken) begin
                    if ((branch_target & AlignMask) != '0) begin
                        mis_d = 1'b1;
                        epc_d = pc_q;
                        pc_d  = TRAP_VECTOR;
                    end else begin
                        pc_d = branch_target;
                    end
                end else if (halt_req) begin
                    state_d = StHalted;
                end else if (fetch_ready && !stall) begin
                    pc_d = pc_q + IncVal;
                end
            end
            StHalted: begin
                if (trap_req) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VECTOR;
                    state_d = StRun;
                end else if (mret) begin
                    pc_d    = epc_q;
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= StBoot;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign PC          = pc_q;
    assign epc         = epc_q;
    assign misaligned  = mis_q;
    assign pc_valid    = (state_q == StRun);
    assign state       = state_q;
    assign PC_plus_inc = pc_q + IncVal;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes reference-model expectations, a monitor
// pops and compares them one time unit after every rising edge.
module tb_pc_unit;

    logic        clk;
    logic        areset;
    logic        fetch_ready, stall, branch_taken, jump, trap_req, mret, halt_req;
    logic [31:0] branch_target, jump_target;
    logic [31:0] PC, PC_plus_inc, epc;
    logic        pc_valid, misaligned;
    logic [1:0]  state;

    pc_unit dut (
        .clk          (clk),
        .areset       (areset),
        .fetch_ready  (fetch_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .trap_req     (trap_req),
        .mret         (mret),
        .halt_req     (halt_req),
        .PC           (PC),
        .pc_valid     (pc_valid),
        .PC_plus_inc  (PC_plus_inc),
        .epc          (epc),
        .misaligned   (misaligned),
        .state        (state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] plus;
        logic [1:0]  st;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Pending stimulus, applied at the next falling edge by step()
    logic        s_areset = 1'b0;
    logic        s_fr = 0, s_stall = 0, s_br = 0, s_j = 0, s_trap = 0, s_mret = 0, s_halt = 0;
    logic [31:0] s_bt = 0, s_jt = 0;

    // Reference model: 0 = boot, 1 = run, 2 = halted
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_epc = 32'h0;
    int          m_st  = 0;
    logic        m_mis = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        if (tgt % 4 != 0) begin
            m_mis = 1'b1;
            m_epc = m_pc;
            m_pc  = 32'h100;
        end else begin
            m_pc = tgt;
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        areset        = s_areset;
        fetch_ready   = s_fr;
        stall         = s_stall;
        branch_taken  = s_br;
        branch_target = s_bt;
        jump          = s_j;
        jump_target   = s_jt;
        trap_req      = s_trap;
        mret          = s_mret;
        halt_req      = s_halt;
        m_mis = 1'b0;
        if (!s_areset) begin
            m_pc = 32'h0; m_epc = 32'h0; m_st = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (s_trap) begin
                m_epc = m_pc; m_pc = 32'h100;
            end else if (s_mret) m_pc = m_epc;
            else if (s_j) redirect_to(s_jt);
            else if (s_br) redirect_to(s_bt);
            else if (s_halt) m_st = 2;
            else if (s_fr && !s_stall) m_pc = m_pc + 32'd4;
        end else begin
            if (s_trap) begin
                m_epc = m_pc; m_pc = 32'h100; m_st = 1;
            end else if (s_mret) begin
                m_pc = m_epc; m_st = 1;
            end
        end
        e.pc = m_pc; e.epc = m_epc; e.plus = m_pc + 32'd4;
        e.st = 2'(m_st); e.valid = (m_st == 1); e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    // Step, then after the edge compare PC against a hand-derived constant
    task automatic step_pc(input string name, input logic [31:0] want);
        step();
        @(posedge clk);
        #2;
        chk(name, PC, want);
    endtask

    task automatic clear();
        s_fr = 0; s_stall = 0; s_br = 0; s_j = 0; s_trap = 0; s_mret = 0; s_halt = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", PC, e.pc);
                chk("sb_epc", epc, e.epc);
                chk("sb_plus_inc", PC_plus_inc, e.plus);
                chk("sb_state", 32'(state), 32'(e.st));
                chk("sb_pc_valid", 32'(pc_valid), 32'(e.valid));
                chk("sb_misaligned", 32'(misaligned), 32'(e.mis));
            end
        end
    end

    initial begin : stimulus
        areset = 1'b0;
        fetch_ready = 0; stall = 0; branch_taken = 0; jump = 0; trap_req = 0;
        mret = 0; halt_req = 0; branch_target = 0; jump_target = 0;

        // Reset and boot
        s_fr = 1;
        step(); step();
        s_areset = 1;
        step_pc("boot_pc", 32'h0);
        step_pc("run_pc4", 32'h4);
        step_pc("run_pc8", 32'h8);
        step_pc("run_pcc", 32'hC);
        @(posedge clk);
        #2;
        areset = 1'b0;
        #1;
        chk("async_pc", PC, 32'h0);
        chk("async_valid", 32'(pc_valid), 32'h0);
        chk("async_state", 32'(state), 32'h0);
        m_pc = 32'h0; m_epc = 32'h0; m_st = 0; m_mis = 1'b0;
        s_areset = 0;
        step();
        s_areset = 1;
        step(); step(); step_pc("adv_to_8", 32'h8);

        // Stall and handshake
        s_stall = 1;
        step_pc("stall1", 32'h8); step_pc("stall2", 32'h8); step_pc("stall3", 32'h8);
        s_stall = 0; s_fr = 0;
        step_pc("no_ready", 32'h8);
        s_fr = 1;
        step_pc("ready_adv", 32'hC);

        // Redirect priority and misaligned branch
        clear();
        s_j = 1; s_jt = 32'h200; s_br = 1; s_bt = 32'h300; s_stall = 1;
        step_pc("jump_wins", 32'h200);
        clear();
        s_br = 1; s_bt = 32'h302;
        step_pc("misaligned_br", 32'h100);
        chk("misaligned_pulse", 32'(misaligned), 32'h1);
        chk("misaligned_epc", epc, 32'h200);
        clear();
        step();

        // Trap and return
        s_j = 1; s_jt = 32'h40; step(); clear();
        s_trap = 1;
        step_pc("trap_pc", 32'h100);
        chk("trap_epc", epc, 32'h40);
        clear(); s_fr = 1; step(); step(); clear();
        s_mret = 1;
        step_pc("mret_pc", 32'h40);
        s_trap = 1;
        step_pc("trap_over_mret", 32'h100);
        clear();

        // Halt and wake
        s_j = 1; s_jt = 32'h80; step(); clear();
        s_halt = 1;
        step_pc("halt_pc", 32'h80);
        chk("halt_state", 32'(state), 32'h2);
        clear(); s_fr = 1; s_j = 1; s_jt = 32'h200;
        for (int i = 0; i < 5; i++) step_pc("halted_hold", 32'h80);
        s_trap = 1;
        step_pc("wake_pc", 32'h100);
        chk("wake_epc", epc, 32'h80);
        chk("wake_state", 32'(state), 32'h1);
        clear();

        // Wrap-around
        s_j = 1; s_jt = 32'hFFFF_FFFC;
        step_pc("jump_top", 32'hFFFF_FFFC);
        chk("plus_inc_wrap", PC_plus_inc, 32'h0);
        clear(); s_fr = 1;
        step_pc("wrap_pc", 32'h0);
        chk("wrap_no_mis", 32'(misaligned), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            s_areset = ($urandom_range(0, 99) != 0);
            s_fr     = 1'($urandom_range(0, 1));
            s_stall  = ($urandom_range(0, 3) == 0);
            s_br     = ($urandom_range(0, 7) == 0);
            s_j      = ($urandom_range(0, 7) == 0);
            s_trap   = ($urandom_range(0, 15) == 0);
            s_mret   = ($urandom_range(0, 15) == 0);
            s_halt   = ($urandom_range(0, 31) == 0);
            s_bt     = $urandom();
            s_jt     = $urandom();
            if ($urandom_range(0, 3) != 0) s_bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) s_jt[1:0] = 2'b00;
            step();
        end
        clear();
        s_areset = 1;
        step();
        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V 32I fetch stage; next generation of the plain load-enabled PC register.
- Holds the fetch PC and sequences it under several controls: fetch handshake, pipeline stall, branch/jump redirect, trap entry, trap return (mret) and halt.
- Sits between the control/execute logic and instruction memory.
- Holds the exception PC (epc) and detects misaligned control-flow targets.

Parameters:
- XLEN, 32, PC / target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry or misaligned target.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero. 2 = word aligned; 1 = halfword aligned.

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  asynchronous active-low reset
- fetch_ready  in  1  instruction memory accepts the current PC this cycle
- stall  in  1  hold the PC; blocks sequential advance only
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  XLEN  branch destination
- jump  in  1  unconditional jump (jal/jalr)
- jump_target  in  XLEN  jump destination
- trap_req  in  1  exception or interrupt request
- mret  in  1  return from trap
- halt_req  in  1  stop fetching
- PC  out  XLEN  current fetch address
- pc_valid  out  1  PC is a valid fetch request
- PC_plus_inc  out  XLEN  PC + INC, combinational, for the link register
- epc  out  XLEN  saved exception PC
- misaligned  out  1  one-cycle pulse: a redirect target was misaligned
- state  out  2  FSM state: 0 = BOOT, 1 = RUN, 2 = HALTED

Behaviour:
- Reset (areset = 0, asynchronous, at any time including mid-operation):
  - PC = RESET_VECTOR, epc = 0, pc_valid = 0, misaligned = 0, state = BOOT.
  - All inputs are ignored while reset is asserted.
- BOOT:
  - Lasts exactly one clock after reset is released. pc_valid = 0, PC holds RESET_VECTOR, all inputs ignored.
  - Next state is RUN.
- RUN:
  - pc_valid = 1.
  - At each rising edge, the first matching rule below applies (highest priority first).
- RUN priority, highest first:
  1. trap_req: epc <= PC; PC <= TRAP_VECTOR.
  2. mret: PC <= epc.
  3. jump: if jump_target[ALIGN_BITS-1:0] != 0, treat as a misaligned trap (misaligned = 1 next cycle, epc <= PC, PC <= TRAP_VECTOR). Otherwise PC <= jump_target.
  4. branch_taken: same misaligned check and handling on branch_target; otherwise PC <= branch_target.
  5. halt_req: PC holds; state <= HALTED.
  6. fetch_ready & ~stall: PC <= PC + INC, modulo 2^XLEN (0xFFFF_FFFC + 4 wraps to 0, no flag).
  7. Otherwise PC holds.
- Redirect independence: rules 1-4 take effect regardless of stall or fetch_ready.
- Redirect latency: one cycle. The new PC is visible after the edge at which the request is sampled.
- Simultaneous requests: the higher-priority request wins; all lower requests in that cycle are dropped, not queued.
- Combined trap_req and mret: trap wins; epc is overwritten with the current PC.
- HALTED:
  - pc_valid = 0; PC and epc hold.
  - stall, fetch_ready, branch_taken, jump and halt_req are ignored.
  - trap_req: epc <= PC; PC <= TRAP_VECTOR; state <= RUN (interrupt wake-up).
  - mret: PC <= epc; state <= RUN.
- misaligned:
  - Registered; high for exactly one cycle after the offending edge, otherwise 0.
  - Never asserted for trap or mret targets; TRAP_VECTOR and epc are trusted.
- PC_plus_inc = PC + INC, truncated to XLEN bits, valid in every state.
- No combinational path from any input to PC, pc_valid, epc or misaligned.

Test Plan:
1. Reset/boot sequence:
   - Stimulus: hold areset = 0 for 2 clocks, release, fetch_ready = 1.
   - Response: cycle 0 PC = 0x0, pc_valid = 0, state = BOOT; cycle 1 state = RUN, pc_valid = 1, PC = 0x0; then PC = 0x4, 0x8, 0xC.
   - Then assert areset mid-run.
   - Response: PC = 0x0 and pc_valid = 0 immediately, without waiting for a clock edge.
2. Stall and handshake:
   - Stimulus: at PC = 0x8, stall = 1 for 3 cycles.
   - Response: PC stays 0x8.
   - Stimulus: stall = 0, fetch_ready = 0.
   - Response: PC still 0x8.
   - Stimulus: fetch_ready = 1.
   - Response: PC = 0xC.
3. Redirect priority:
   - Stimulus: jump = 1 (jump_target = 0x200), branch_taken = 1 (branch_target = 0x300), stall = 1, all in the same cycle.
   - Response: PC = 0x200 next cycle.
   - Stimulus: branch_taken only, target 0x302.
   - Response: misaligned = 1 for one cycle, PC = 0x100, epc = 0x200.
4. Trap and return:
   - Stimulus: at PC = 0x40, trap_req = 1.
   - Response: PC = 0x100, epc = 0x40.
   - Stimulus: two sequential advances, then mret = 1.
   - Response: PC = 0x40.
   - Stimulus: trap_req and mret together.
   - Response: trap wins.
5. Halt and wake:
   - Stimulus: halt_req at PC = 0x80.
   - Response: state = HALTED, pc_valid = 0, PC = 0x80 held for 5 cycles even with fetch_ready = 1 and jump = 1.
   - Stimulus: trap_req = 1.
   - Response: state = RUN, PC = 0x100, epc = 0x80.
6. Wrap-around:
   - Stimulus: jump to 0xFFFF_FFFC, then fetch_ready = 1.
   - Response: PC = 0x0000_0000 next cycle; PC_plus_inc = 0x0 while PC = 0xFFFF_FFFC; no misaligned pulse.
